// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier (MULT/MULTU), BITS_PER_CYCLE multiplier bits retired per cycle.
// Start accepted at edge k gives Done in the cycle after edge k+N+1; Start is ignored while Busy.
module seq_multiplier #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Signed,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);
   localparam int SW = WIDTH + BITS_PER_CYCLE;

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH:0]   acc_q;
   logic [2*WIDTH:0]   acc_d;
   logic [WIDTH-1:0]   a_q;
   logic               neg_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic [SW-1:0]      sum_d;
   logic [2*WIDTH-1:0] prod_d;
   logic [WIDTH-1:0]   mag_a_d;
   logic [WIDTH-1:0]   mag_b_d;

   always_comb begin
      mag_a_d = (Signed && A[WIDTH-1]) ? -A : A;
      mag_b_d = (Signed && B[WIDTH-1]) ? -B : B;
      // Upper half plus the partial product can exceed WIDTH bits; keep every carry bit.
      sum_d   = SW'(acc_q[2*WIDTH:WIDTH]) + SW'(a_q) * SW'(acc_q[BITS_PER_CYCLE-1:0]);
      acc_d   = {1'b0, sum_d, acc_q[WIDTH-1:BITS_PER_CYCLE]};
      prod_d  = (neg_q && (acc_q[2*WIDTH-1:0] != '0)) ? -acc_q[2*WIDTH-1:0]
                                                       : acc_q[2*WIDTH-1:0];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         a_q     <= '0;
         neg_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         case (state_q)
            CALC: begin
               if (cnt_q == CW'(N)) begin
                  state_q <= FIN;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  hi_q    <= prod_d[2*WIDTH-1:WIDTH];
                  lo_q    <= prod_d[WIDTH-1:0];
               end else begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            // IDLE and FIN both accept a new request; FIN->CALC gives back-to-back issue.
            default: begin
               done_q <= 1'b0;
               if (Start) begin
                  state_q <= CALC;
                  busy_q  <= 1'b1;
                  cnt_q   <= '0;
                  a_q     <= mag_a_d;
                  acc_q   <= {{(WIDTH+1){1'b0}}, mag_b_d};
                  neg_q   <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
               end else begin
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end

   assign Busy = busy_q;
   assign Done = done_q;
   assign Hi   = hi_q;
   assign Lo   = lo_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: 32-bit default instance plus three 8-bit instances (1/2/4 bits per cycle).
module tb_seq_multiplier;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              sgn;
   logic [31:0]       a;
   logic [31:0]       b;
   logic              busy;
   logic              done;
   logic [31:0]       hi;
   logic [31:0]       lo;
   logic [2:0]        busy8;
   logic [2:0]        done8;
   logic [2:0][7:0]   hi8;
   logic [2:0][7:0]   lo8;

   int vectors    = 0;
   int miscompares = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      bit          s;
      logic [63:0] p;
   } vec_t;

   always #5 clk = ~clk;

   seq_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
      .Clk(clk), .Reset(rst), .Start(start), .Signed(sgn), .A(a), .B(b),
      .Busy(busy), .Done(done), .Hi(hi), .Lo(lo));

   seq_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8_1 (
      .Clk(clk), .Reset(rst), .Start(start), .Signed(sgn), .A(a[7:0]), .B(b[7:0]),
      .Busy(busy8[0]), .Done(done8[0]), .Hi(hi8[0]), .Lo(lo8[0]));

   seq_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(2)) dut8_2 (
      .Clk(clk), .Reset(rst), .Start(start), .Signed(sgn), .A(a[7:0]), .B(b[7:0]),
      .Busy(busy8[1]), .Done(done8[1]), .Hi(hi8[1]), .Lo(lo8[1]));

   seq_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut8_4 (
      .Clk(clk), .Reset(rst), .Start(start), .Signed(sgn), .A(a[7:0]), .B(b[7:0]),
      .Busy(busy8[2]), .Done(done8[2]), .Hi(hi8[2]), .Lo(lo8[2]));

   // Reference: plain integer multiply of the w-bit operands, truncated to 2w bits.
   function automatic logic [63:0] ref_prod(input logic [31:0] xa, input logic [31:0] xb,
                                            input bit s, input int w);
      longint          x;
      longint          y;
      logic [63:0]     p;
      logic [63:0]     mask;
      if (s) begin
         x = xa[w-1] ? longint'(xa) - (longint'(1) << w) : longint'(xa);
         y = xb[w-1] ? longint'(xb) - (longint'(1) << w) : longint'(xb);
         p = x * y;
      end else begin
         p = {32'b0, xa} * {32'b0, xb};
      end
      mask = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
      return p & mask;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op on the 32-bit unit (caller guarantees it is idle or in FIN) and wait for Done.
   task automatic run32(input logic [31:0] ia, input logic [31:0] ib, input bit is,
                        output logic [63:0] res, output int lat, output bit busy0,
                        output bit ovl, output bit leak);
      logic [63:0] prev;
      prev  = {hi, lo};
      a     = ia;
      b     = ib;
      sgn   = is;
      start = 1'b1;
      tick();
      start = 1'b0;
      busy0 = busy;
      a     = $urandom;
      b     = $urandom;
      sgn   = 1'($urandom_range(1));
      lat   = 0;
      ovl   = 1'b0;
      leak  = 1'b0;
      do begin
         tick();
         lat++;
         if (busy && done) ovl = 1'b1;
         if (!done && ({hi, lo} !== prev)) leak = 1'b1;
      end while (!done && lat < 100);
      res = {hi, lo};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      repeat (3) tick();
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
      vectors++;
      if (hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi got %h want 0", hi); end
      vectors++;
      if (lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo got %h want 0", lo); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_directed();
      vec_t        tv[6];
      logic [63:0] res;
      int          lat;
      bit          b0, ovl, leak;
      tv[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001};
      tv[1] = '{32'hFFFFFFFF, 32'h00000007, 1'b1, 64'hFFFFFFFF_FFFFFFF9};
      tv[2] = '{32'hFFFFFFFF, 32'h00000007, 1'b0, 64'h00000006_FFFFFFF9};
      tv[3] = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000};
      tv[4] = '{32'h80000000, 32'h00000000, 1'b1, 64'h0};
      tv[5] = '{32'h00000000, 32'hFFFFFFFB, 1'b1, 64'h0};
      for (int i = 0; i < 6; i++) begin
         run32(tv[i].a, tv[i].b, tv[i].s, res, lat, b0, ovl, leak);
         vectors++;
         if (res !== tv[i].p) begin
            miscompares++;
            $display("FAIL directed%0d_product got %h want %h", i, res, tv[i].p);
         end
         vectors++;
         if (lat != 33) begin miscompares++; $display("FAIL directed%0d_latency got %0d want 33", i, lat); end
         vectors++;
         if (b0 !== 1'b1) begin miscompares++; $display("FAIL directed%0d_busy got %b want 1", i, b0); end
         vectors++;
         if (ovl || leak) begin
            miscompares++;
            $display("FAIL directed%0d_hold busy_done_overlap=%b partial_visible=%b want 0/0", i, ovl, leak);
         end
         tick();
         vectors++;
         if (done !== 1'b0) begin miscompares++; $display("FAIL directed%0d_pulse done got %b want 0", i, done); end
      end
   endtask

   task automatic test_reset_abort();
      logic [63:0] res, exp;
      logic [31:0] fa, fb;
      int          lat;
      bit          b0, ovl, leak, seen;
      run32(32'h12345678, 32'h9ABCDEF0, 1'b0, res, lat, b0, ovl, leak);
      tick();
      a = $urandom | 32'h1;
      b = $urandom | 32'h1;
      sgn = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", busy); end
      vectors++;
      if ({hi, lo} !== 64'h0) begin miscompares++; $display("FAIL abort_hilo got %h want 0", {hi, lo}); end
      seen = done;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (done) seen = 1'b1;
      end
      vectors++;
      if (seen) begin miscompares++; $display("FAIL abort_no_done got done=1 want no Done"); end
      fa = $urandom;
      fb = $urandom;
      exp = ref_prod(fa, fb, 1'b1, 32);
      run32(fa, fb, 1'b1, res, lat, b0, ovl, leak);
      vectors++;
      if (res !== exp) begin miscompares++; $display("FAIL abort_fresh_product got %h want %h", res, exp); end
      vectors++;
      if (lat != 33) begin miscompares++; $display("FAIL abort_fresh_latency got %0d want 33", lat); end
      tick();
   endtask

   task automatic test_start_held();
      logic [31:0] a1, b1, a2, b2;
      logic [63:0] exp1, exp2;
      int          lat;
      a1 = $urandom; b1 = $urandom | 32'h8000_0000;
      a2 = $urandom; b2 = $urandom;
      exp1 = ref_prod(a1, b1, 1'b1, 32);
      exp2 = ref_prod(a2, b2, 1'b0, 32);
      a = a1; b = b1; sgn = 1'b1; start = 1'b1;
      tick();
      lat = 0;
      do begin
         a = $urandom;
         b = $urandom;
         sgn = 1'($urandom_range(1));
         tick();
         lat++;
      end while (!done && lat < 100);
      vectors++;
      if (lat != 33) begin miscompares++; $display("FAIL held_latency got %0d want 33", lat); end
      vectors++;
      if ({hi, lo} !== exp1) begin miscompares++; $display("FAIL held_product got %h want %h", {hi, lo}, exp1); end
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL held_fin_busy got %b want 0", busy); end
      a = a2; b = b2; sgn = 1'b0;
      tick();
      start = 1'b0;
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_issue busy=%b done=%b want 1/0", busy, done);
      end
      a = $urandom; b = $urandom;
      lat = 0;
      do begin tick(); lat++; end while (!done && lat < 100);
      vectors++;
      if (lat != 33) begin miscompares++; $display("FAIL b2b_latency got %0d want 33", lat); end
      vectors++;
      if ({hi, lo} !== exp2) begin miscompares++; $display("FAIL b2b_product got %h want %h", {hi, lo}, exp2); end
      tick();
   endtask

   task automatic test_random32();
      logic [31:0] cn[5];
      logic [31:0] ra, rb;
      bit          rs, b0, ovl, leak;
      logic [63:0] res, exp;
      int          lat;
      cn = '{32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h1};
      for (int i = 0; i < 30; i++) begin
         ra = ($urandom_range(3) == 0) ? cn[$urandom_range(4)] : $urandom;
         rb = ($urandom_range(3) == 0) ? cn[$urandom_range(4)] : $urandom;
         rs = 1'($urandom_range(1));
         exp = ref_prod(ra, rb, rs, 32);
         run32(ra, rb, rs, res, lat, b0, ovl, leak);
         vectors++;
         if (res !== exp) begin
            miscompares++;
            $display("FAIL rand%0d_product a=%h b=%h s=%b got %h want %h", i, ra, rb, rs, res, exp);
         end
         vectors++;
         if (lat != 33 || ovl || leak) begin
            miscompares++;
            $display("FAIL rand%0d_timing latency=%0d overlap=%b partial=%b want 33/0/0", i, lat, ovl, leak);
         end
      end
      tick();
   endtask

   task automatic test_sweep8();
      logic [7:0]  cn[5];
      logic [7:0]  a8, b8;
      bit          s8;
      logic [15:0] exp;
      logic [15:0] got[3];
      int          lat[3];
      int          want_lat[3];
      logic [2:0]  seen;
      cn = '{8'h00, 8'h80, 8'hFF, 8'h7F, 8'h01};
      want_lat = '{9, 5, 3};
      // let the 32-bit unit drain so its cycle budget does not matter here
      repeat (40) tick();
      for (int i = 0; i < 250; i++) begin
         if (i < 50) begin
            s8 = 1'(i % 2);
            a8 = cn[(i / 2) % 5];
            b8 = cn[(i / 10) % 5];
         end else begin
            s8 = 1'($urandom_range(1));
            a8 = 8'($urandom);
            b8 = 8'($urandom);
         end
         exp = 16'(ref_prod({24'h0, a8}, {24'h0, b8}, s8, 8));
         a = {24'($urandom), a8};
         b = {24'($urandom), b8};
         sgn = s8;
         start = 1'b1;
         tick();
         start = 1'b0;
         seen = 3'b000;
         for (int j = 0; j < 3; j++) begin lat[j] = 0; got[j] = 16'h0; end
         for (int c = 1; c <= 20; c++) begin
            tick();
            for (int j = 0; j < 3; j++) begin
               if (!seen[j] && done8[j]) begin
                  seen[j] = 1'b1;
                  lat[j]  = c;
                  got[j]  = {hi8[j], lo8[j]};
               end
            end
            if (seen == 3'b111) break;
         end
         for (int j = 0; j < 3; j++) begin
            vectors++;
            if (got[j] !== exp || lat[j] != want_lat[j]) begin
               miscompares++;
               $display("FAIL sweep8_bpc%0d a=%h b=%h s=%b got %h lat %0d want %h lat %0d",
                        1 << j, a8, b8, s8, got[j], lat[j], exp, want_lat[j]);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      sgn = 1'b0;
      a = 32'h0;
      b = 32'h0;
      test_reset();
      test_directed();
      test_reset_abort();
      test_start_held();
      test_random32();
      test_sweep8();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
